mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 40 ++++
 rtl/mem_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory port of the MEM stage.
// Contains the request side (req/we/addr/wdata/be) and the completion side
// (ready/rdata) that the memory returns.
//
// Handshake: dmem_req is a single-cycle pulse. While it is high, addr, wdata,
// be and we describe the access. The memory answers with exactly one
// dmem_ready pulse, at least one cycle after the request. dmem_rdata is valid
// only in the ready cycle. Only one access is outstanding at any time, and a
// new request is never issued before the previous ready has been seen.
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;

   // Pipeline side: issues requests and consumes the completion.
   modport master (
      output dmem_req,
      output dmem_we,
      output dmem_addr,
      output dmem_wdata,
      output dmem_be,
      input  dmem_ready,
      input  dmem_rdata
   );

   // Memory side: accepts requests and returns the completion.
   modport slave (
      input  dmem_req,
      input  dmem_we,
      input  dmem_addr,
      input  dmem_wdata,
      input  dmem_be,
      output dmem_ready,
      output dmem_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory loads and stores and stalls the
// front of the pipeline until each one completes. It also formats byte and
// halfword lanes, resolves branches and jumps into a PC redirect, and owns
// the MEM/WB register.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned halfword and
// word accesses. A trapped access issues no request and produces a one-cycle
// mem_misalign pulse.
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_mem_ctrl_reg_write,
   input  logic        ex_mem_ctrl_mem_to_reg,
   input  logic        ex_mem_ctrl_mem_write,
   input  logic        ex_mem_ctrl_jump,
   input  logic        ex_mem_ctrl_branch,
   input  logic [2:0]  ex_mem_ctrl_branch_type,
   input  logic [2:0]  ex_mem_ctrl_load_type,
   input  logic [1:0]  ex_mem_ctrl_store_type,
   input  logic [31:0] ex_mem_alu_out,
   input  logic [31:0] ex_mem_reg_b_data,
   input  logic [31:0] ex_mem_pc_branch,
   input  logic [31:0] ex_mem_pc_jump,
   input  logic [4:0]  ex_mem_rd,
   input  logic [5:0]  ex_mem_alu_cond,
   mem_stage_if.master dmem,
   output logic        stall_mem,
   output logic        pc_redirect,
   output logic [31:0] pc_target,
   output logic        mem_wb_ctrl_reg_write,
   output logic [4:0]  mem_wb_rd,
   output logic [31:0] mem_wb_data,
`ifdef MEM_ALIGN_CHECK_EN
   output logic        mem_misalign,
`endif
   output logic        state_dbg
);

   // Load type encodings
   localparam logic [2:0] LD_LW  = 3'd0;
   localparam logic [2:0] LD_LB  = 3'd1;
   localparam logic [2:0] LD_LBU = 3'd2;
   localparam logic [2:0] LD_LH  = 3'd3;
   localparam logic [2:0] LD_LHU = 3'd4;

   // Store type encodings (3 behaves like SW)
   localparam logic [1:0] ST_SB  = 2'd1;
   localparam logic [1:0] ST_SH  = 2'd2;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t      state;
   logic        is_mem;
   logic        misalign;
   logic        access;
   logic        cond_taken;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_val;
   logic [31:0] wb_value;

   assign is_mem = ex_mem_ctrl_mem_to_reg | ex_mem_ctrl_mem_write;

`ifdef MEM_ALIGN_CHECK_EN
   // Flag halfword accesses on odd addresses and word accesses off a word
   // boundary. Byte accesses are always aligned.
   always_comb begin
      misalign = 1'b0;
      if (ex_mem_ctrl_mem_to_reg) begin
         case (ex_mem_ctrl_load_type)
            LD_LB, LD_LBU: misalign = 1'b0;
            LD_LH, LD_LHU: misalign = ex_mem_alu_out[0];
            default:       misalign = (ex_mem_alu_out[1:0] != 2'b00);
         endcase
      end else if (ex_mem_ctrl_mem_write) begin
         case (ex_mem_ctrl_store_type)
            ST_SB:   misalign = 1'b0;
            ST_SH:   misalign = ex_mem_alu_out[0];
            default: misalign = (ex_mem_alu_out[1:0] != 2'b00);
         endcase
      end
   end
`else
   // Without the check the low address bits are simply ignored by the lane
   // logic, so no access is ever rejected.
   assign misalign = 1'b0;
`endif

   // A memory instruction that will actually reach the memory
   assign access = is_mem & ~misalign;

   // Request pulse and stall. The stall drops in the ready cycle, so the
   // frozen EX/MEM register advances exactly once per access and the
   // request is never repeated.
   always_comb begin
      dmem.dmem_req = 1'b0;
      stall_mem     = 1'b0;
      if (!rst) begin
         case (state)
            S_IDLE: begin
               dmem.dmem_req = access;
               stall_mem     = access;
            end
            S_WAIT: begin
               stall_mem     = ~dmem.dmem_ready;
            end
            default: begin
               dmem.dmem_req = 1'b0;
               stall_mem     = 1'b0;
            end
         endcase
      end
   end

   // Store lane formatting. Loads keep all byte enables set, and the memory
   // ignores wdata for them.
   always_comb begin
      dmem.dmem_wdata = ex_mem_reg_b_data;
      dmem.dmem_be    = 4'b1111;
      if (ex_mem_ctrl_mem_write) begin
         case (ex_mem_ctrl_store_type)
            ST_SB: begin
               dmem.dmem_wdata = {4{ex_mem_reg_b_data[7:0]}};
               dmem.dmem_be    = 4'b0001 << ex_mem_alu_out[1:0];
            end
            ST_SH: begin
               dmem.dmem_wdata = {2{ex_mem_reg_b_data[15:0]}};
               dmem.dmem_be    = ex_mem_alu_out[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
               dmem.dmem_wdata = ex_mem_reg_b_data;
               dmem.dmem_be    = 4'b1111;
            end
         endcase
      end
   end

   assign dmem.dmem_addr = {ex_mem_alu_out[31:2], 2'b00};
   assign dmem.dmem_we   = dmem.dmem_req & ex_mem_ctrl_mem_write;

   // Little-endian lane extraction from the returned word
   always_comb begin
      case (ex_mem_alu_out[1:0])
         2'd0:    lane_byte = dmem.dmem_rdata[7:0];
         2'd1:    lane_byte = dmem.dmem_rdata[15:8];
         2'd2:    lane_byte = dmem.dmem_rdata[23:16];
         default: lane_byte = dmem.dmem_rdata[31:24];
      endcase
      lane_half = ex_mem_alu_out[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
      case (ex_mem_ctrl_load_type)
         LD_LB:   load_val = {{24{lane_byte[7]}}, lane_byte};
         LD_LBU:  load_val = {24'h000000, lane_byte};
         LD_LH:   load_val = {{16{lane_half[15]}}, lane_half};
         LD_LHU:  load_val = {16'h0000, lane_half};
         default: load_val = dmem.dmem_rdata;
      endcase
      wb_value = ex_mem_ctrl_mem_to_reg ? load_val : ex_mem_alu_out;
   end

   // Branch condition select. Types 6 and 7 never take the branch.
   always_comb begin
      case (ex_mem_ctrl_branch_type)
         3'd0:    cond_taken = ex_mem_alu_cond[0];
         3'd1:    cond_taken = ex_mem_alu_cond[1];
         3'd2:    cond_taken = ex_mem_alu_cond[2];
         3'd3:    cond_taken = ex_mem_alu_cond[3];
         3'd4:    cond_taken = ex_mem_alu_cond[4];
         3'd5:    cond_taken = ex_mem_alu_cond[5];
         default: cond_taken = 1'b0;
      endcase
      pc_redirect = ~rst & ~stall_mem &
                    (ex_mem_ctrl_jump | (ex_mem_ctrl_branch & cond_taken));
   end

   // A jump takes priority over a branch when both are set
   assign pc_target = ex_mem_ctrl_jump ? ex_mem_pc_jump : ex_mem_pc_branch;

   // Access FSM and MEM/WB register. Every stalled cycle writes a bubble.
   // Reset drops any outstanding access, and a late ready is then ignored
   // because IDLE never looks at dmem_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state                 <= S_IDLE;
         mem_wb_ctrl_reg_write <= 1'b0;
         mem_wb_rd             <= 5'd0;
         mem_wb_data           <= 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
         mem_misalign          <= 1'b0;
`endif
      end else begin
`ifdef MEM_ALIGN_CHECK_EN
         mem_misalign <= 1'b0;
`endif
         case (state)
            S_IDLE:  if (access) state <= S_WAIT;
            S_WAIT:  if (dmem.dmem_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase

         if (stall_mem) begin
            mem_wb_ctrl_reg_write <= 1'b0;
            mem_wb_rd             <= 5'd0;
            mem_wb_data           <= 32'd0;
         end else if (state == S_IDLE && misalign) begin
            mem_wb_ctrl_reg_write <= 1'b0;
            mem_wb_rd             <= 5'd0;
            mem_wb_data           <= 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
            mem_misalign          <= 1'b1;
`endif
         end else begin
            mem_wb_ctrl_reg_write <= ex_mem_ctrl_reg_write;
            mem_wb_rd             <= ex_mem_rd;
            mem_wb_data           <= wb_value;
         end
      end
   end

   assign state_dbg = (state == S_WAIT);

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of single-cycle ALU/branch/jump
// vectors, then hand-written load/store, reset-in-WAIT and (when
// MEM_ALIGN_CHECK_EN is defined) misalignment sequences.
module tb_mem_stage;

   logic        clk;
   logic        rst;
   logic        reg_write, mem_to_reg, mem_write, jump, branch;
   logic [2:0]  branch_type, load_type;
   logic [1:0]  store_type;
   logic [31:0] alu_out, reg_b_data, pc_branch, pc_jump;
   logic [4:0]  rd;
   logic [5:0]  alu_cond;
   logic        stall_mem, pc_redirect;
   logic [31:0] pc_target;
   logic        mem_wb_ctrl_reg_write;
   logic [4:0]  mem_wb_rd;
   logic [31:0] mem_wb_data;
   logic        state_dbg;
`ifdef MEM_ALIGN_CHECK_EN
   logic        mem_misalign;
`endif

   int checks = 0;
   int errors = 0;

   // Captured request fields for the memory sequences
   int          reqs, stalls, bad_bubbles;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_be;
   logic        cap_we;

   mem_stage_if dmem_bus();

   mem_stage dut (
      .clk                     (clk),
      .rst                     (rst),
      .ex_mem_ctrl_reg_write   (reg_write),
      .ex_mem_ctrl_mem_to_reg  (mem_to_reg),
      .ex_mem_ctrl_mem_write   (mem_write),
      .ex_mem_ctrl_jump        (jump),
      .ex_mem_ctrl_branch      (branch),
      .ex_mem_ctrl_branch_type (branch_type),
      .ex_mem_ctrl_load_type   (load_type),
      .ex_mem_ctrl_store_type  (store_type),
      .ex_mem_alu_out          (alu_out),
      .ex_mem_reg_b_data       (reg_b_data),
      .ex_mem_pc_branch        (pc_branch),
      .ex_mem_pc_jump          (pc_jump),
      .ex_mem_rd               (rd),
      .ex_mem_alu_cond         (alu_cond),
      .dmem                    (dmem_bus),
      .stall_mem               (stall_mem),
      .pc_redirect             (pc_redirect),
      .pc_target               (pc_target),
      .mem_wb_ctrl_reg_write   (mem_wb_ctrl_reg_write),
      .mem_wb_rd               (mem_wb_rd),
      .mem_wb_data             (mem_wb_data),
`ifdef MEM_ALIGN_CHECK_EN
      .mem_misalign            (mem_misalign),
`endif
      .state_dbg               (state_dbg)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rw;
      logic        jump;
      logic        branch;
      logic [2:0]  btype;
      logic [5:0]  cond;
      logic [31:0] alu;
      logic [31:0] pcb;
      logic [31:0] pcj;
      logic [4:0]  rd;
      logic        exp_redirect;
      logic [31:0] exp_target;
      logic        exp_wb_we;
      logic [4:0]  exp_wb_rd;
      logic [31:0] exp_wb_data;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      reg_write = 0; mem_to_reg = 0; mem_write = 0; jump = 0; branch = 0;
      branch_type = 0; load_type = 0; store_type = 0;
      alu_out = 0; reg_b_data = 0; pc_branch = 0; pc_jump = 0; rd = 0; alu_cond = 0;
   endtask

   // Memory responder: the request is expected in the cycle the instruction
   // is applied; ready is returned lat cycles later. Inputs must already be
   // applied (just after a rising edge).
   task automatic mem_txn(input int lat, input logic [31:0] word);
      reqs = 0; stalls = 0; bad_bubbles = 0;
      cap_addr = 0; cap_wdata = 0; cap_be = 0; cap_we = 0;
      for (int cyc = 0; cyc <= lat; cyc++) begin
         if (cyc == lat) begin
            dmem_bus.dmem_ready = 1'b1;
            dmem_bus.dmem_rdata = word;
         end
         #1;
         if (dmem_bus.dmem_req) begin
            reqs++;
            cap_addr  = dmem_bus.dmem_addr;
            cap_wdata = dmem_bus.dmem_wdata;
            cap_be    = dmem_bus.dmem_be;
            cap_we    = dmem_bus.dmem_we;
         end
         if (stall_mem) stalls++;
         @(posedge clk); #1;
         dmem_bus.dmem_ready = 1'b0;
         dmem_bus.dmem_rdata = 32'd0;
         if (cyc < lat && (mem_wb_ctrl_reg_write !== 1'b0 || mem_wb_rd !== 5'd0 ||
                           mem_wb_data !== 32'd0))
            bad_bubbles++;
      end
      clear_inputs();
   endtask

   task automatic check_txn(input string name, input int lat,
                            input logic [31:0] e_addr, input logic [31:0] e_wdata,
                            input logic [3:0] e_be, input logic e_we,
                            input logic e_wb_we, input logic [4:0] e_rd,
                            input logic [31:0] e_data);
      check({name, " req_count"},   reqs, 1);
      check({name, " stall_count"}, stalls, lat);
      check({name, " bubbles"},     bad_bubbles, 0);
      check({name, " addr"},        cap_addr, e_addr);
      check({name, " wdata"},       cap_wdata, e_wdata);
      check({name, " be"},          {28'd0, cap_be}, {28'd0, e_be});
      check({name, " we"},          {31'd0, cap_we}, {31'd0, e_we});
      check({name, " wb_we"},       {31'd0, mem_wb_ctrl_reg_write}, {31'd0, e_wb_we});
      check({name, " wb_rd"},       {27'd0, mem_wb_rd}, {27'd0, e_rd});
      check({name, " wb_data"},     mem_wb_data, e_data);
   endtask

   initial begin
      //                 name      rw jmp br  bt    cond       alu           pcb           pcj          rd  redir target        we rd  data
      vecs[0] = '{"add",      1, 0, 0, 3'd0, 6'b000000, 32'h00000055, 32'h00000000, 32'h00000000, 9,  0, 32'h00000000, 1, 9,  32'h00000055};
      vecs[1] = '{"bltz_t",   0, 0, 1, 3'd5, 6'b100000, 32'h00000020, 32'h00400020, 32'h00000000, 0,  1, 32'h00400020, 0, 0,  32'h00000020};
      vecs[2] = '{"bltz_nt",  0, 0, 1, 3'd5, 6'b000000, 32'h00000020, 32'h00400020, 32'h00000000, 0,  0, 32'h00400020, 0, 0,  32'h00000020};
      vecs[3] = '{"beq_t",    0, 0, 1, 3'd0, 6'b000001, 32'h00000000, 32'h00401000, 32'h00000000, 0,  1, 32'h00401000, 0, 0,  32'h00000000};
      vecs[4] = '{"bne_nt",   0, 0, 1, 3'd1, 6'b000001, 32'h00000001, 32'h00402000, 32'h00000000, 0,  0, 32'h00402000, 0, 0,  32'h00000001};
      vecs[5] = '{"btype6",   0, 0, 1, 3'd6, 6'b111111, 32'h00000000, 32'h00403000, 32'h00000000, 0,  0, 32'h00403000, 0, 0,  32'h00000000};
      vecs[6] = '{"jmp_br",   0, 1, 1, 3'd0, 6'b000001, 32'h00000000, 32'h00404000, 32'h00400100, 0,  1, 32'h00400100, 0, 0,  32'h00000000};
      vecs[7] = '{"jal",      1, 1, 0, 3'd0, 6'b000000, 32'h0040000C, 32'h00000000, 32'h00400200, 31, 1, 32'h00400200, 1, 31, 32'h0040000C};
      vecs[8] = '{"bgtz_t",   0, 0, 1, 3'd3, 6'b001000, 32'h00000000, 32'h00405000, 32'h00000000, 0,  1, 32'h00405000, 0, 0,  32'h00000000};

      // Reset with a load and a jump both presented: everything forced low
      clear_inputs();
      dmem_bus.dmem_ready = 1'b0;
      dmem_bus.dmem_rdata = 32'd0;
      rst = 1'b1;
      jump = 1'b1; mem_to_reg = 1'b1; pc_jump = 32'h00400000;
      repeat (2) @(posedge clk);
      #1;
      check("rst req",      {31'd0, dmem_bus.dmem_req}, 0);
      check("rst stall",    {31'd0, stall_mem}, 0);
      check("rst redirect", {31'd0, pc_redirect}, 0);
      check("rst wb_we",    {31'd0, mem_wb_ctrl_reg_write}, 0);
      check("rst wb_rd",    {27'd0, mem_wb_rd}, 0);
      check("rst wb_data",  mem_wb_data, 0);
      check("rst state",    {31'd0, state_dbg}, 0);
      rst = 1'b0;
      clear_inputs();
      @(posedge clk); #1;

      // Single-cycle vectors
      for (int i = 0; i < 9; i++) begin
         reg_write   = vecs[i].rw;
         jump        = vecs[i].jump;
         branch      = vecs[i].branch;
         branch_type = vecs[i].btype;
         alu_cond    = vecs[i].cond;
         alu_out     = vecs[i].alu;
         pc_branch   = vecs[i].pcb;
         pc_jump     = vecs[i].pcj;
         rd          = vecs[i].rd;
         #1;
         check({vecs[i].name, " redirect"}, {31'd0, pc_redirect}, {31'd0, vecs[i].exp_redirect});
         check({vecs[i].name, " target"},   pc_target, vecs[i].exp_target);
         check({vecs[i].name, " req"},      {31'd0, dmem_bus.dmem_req}, 0);
         check({vecs[i].name, " stall"},    {31'd0, stall_mem}, 0);
         @(posedge clk); #1;
         check({vecs[i].name, " wb_we"},   {31'd0, mem_wb_ctrl_reg_write}, {31'd0, vecs[i].exp_wb_we});
         check({vecs[i].name, " wb_rd"},   {27'd0, mem_wb_rd}, {27'd0, vecs[i].exp_wb_rd});
         check({vecs[i].name, " wb_data"}, mem_wb_data, vecs[i].exp_wb_data);
      end
      clear_inputs();
      @(posedge clk); #1;

      // LB at 0x103, word 0x80FF1234, latency 2
      reg_write = 1; mem_to_reg = 1; load_type = 3'd1; alu_out = 32'h00000103; rd = 5'd4;
      mem_txn(2, 32'h80FF1234);
      check_txn("lb", 2, 32'h00000100, 32'h00000000, 4'b1111, 1'b0, 1'b1, 5'd4, 32'hFFFFFF80);

      // SH at 0x202, rt 0xABCD, latency 3
      mem_write = 1; store_type = 2'd2; alu_out = 32'h00000202; reg_b_data = 32'h0000ABCD;
      mem_txn(3, 32'h00000000);
      check_txn("sh", 3, 32'h00000200, 32'hABCDABCD, 4'b1100, 1'b1, 1'b0, 5'd0, 32'h00000202);

      // LHU at 0x202, latency 1
      reg_write = 1; mem_to_reg = 1; load_type = 3'd4; alu_out = 32'h00000202; rd = 5'd5;
      mem_txn(1, 32'h80FF1234);
      check_txn("lhu", 1, 32'h00000200, 32'h00000000, 4'b1111, 1'b0, 1'b1, 5'd5, 32'h000080FF);

      // LH at 0x302, latency 2
      reg_write = 1; mem_to_reg = 1; load_type = 3'd3; alu_out = 32'h00000302; rd = 5'd6;
      mem_txn(2, 32'h80FF1234);
      check_txn("lh", 2, 32'h00000300, 32'h00000000, 4'b1111, 1'b0, 1'b1, 5'd6, 32'hFFFF80FF);

      // LBU at 0x102, latency 1
      reg_write = 1; mem_to_reg = 1; load_type = 3'd2; alu_out = 32'h00000102; rd = 5'd7;
      mem_txn(1, 32'h80FF1234);
      check_txn("lbu", 1, 32'h00000100, 32'h00000000, 4'b1111, 1'b0, 1'b1, 5'd7, 32'h000000FF);

      // LW at 0x104, latency 4
      reg_write = 1; mem_to_reg = 1; load_type = 3'd0; alu_out = 32'h00000104; rd = 5'd8;
      mem_txn(4, 32'hDEADBEEF);
      check_txn("lw", 4, 32'h00000104, 32'h00000000, 4'b1111, 1'b0, 1'b1, 5'd8, 32'hDEADBEEF);

      // SB at 0x301, rt 0x123456A5, latency 1
      mem_write = 1; store_type = 2'd1; alu_out = 32'h00000301; reg_b_data = 32'h123456A5;
      mem_txn(1, 32'h00000000);
      check_txn("sb", 1, 32'h00000300, 32'hA5A5A5A5, 4'b0010, 1'b1, 1'b0, 5'd0, 32'h00000301);

      // Reset while waiting, then a late ready: no writeback, FSM idle
      reg_write = 1; mem_to_reg = 1; load_type = 3'd0; alu_out = 32'h00000040; rd = 5'd7;
      #1;
      check("rstw req", {31'd0, dmem_bus.dmem_req}, 1);
      @(posedge clk); #1;
      check("rstw in_wait", {31'd0, state_dbg}, 1);
      check("rstw stall",   {31'd0, stall_mem}, 1);
      rst = 1'b1; jump = 1'b1;
      #1;
      check("rstw req_forced",      {31'd0, dmem_bus.dmem_req}, 0);
      check("rstw stall_forced",    {31'd0, stall_mem}, 0);
      check("rstw redirect_forced", {31'd0, pc_redirect}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      clear_inputs();
      dmem_bus.dmem_ready = 1'b1;
      dmem_bus.dmem_rdata = 32'h12345678;
      #1;
      check("rstw idle",       {31'd0, state_dbg}, 0);
      check("rstw late_stall", {31'd0, stall_mem}, 0);
      @(posedge clk); #1;
      dmem_bus.dmem_ready = 1'b0;
      dmem_bus.dmem_rdata = 32'd0;
      check("rstw wb_we",   {31'd0, mem_wb_ctrl_reg_write}, 0);
      check("rstw wb_data", mem_wb_data, 0);
      check("rstw state",   {31'd0, state_dbg}, 0);

`ifdef MEM_ALIGN_CHECK_EN
      // Misaligned LW at 0x101: no request, no stall, bubble, one-cycle pulse
      reg_write = 1; mem_to_reg = 1; load_type = 3'd0; alu_out = 32'h00000101; rd = 5'd3;
      #1;
      check("mis req",   {31'd0, dmem_bus.dmem_req}, 0);
      check("mis stall", {31'd0, stall_mem}, 0);
      @(posedge clk); #1;
      clear_inputs();
      check("mis pulse", {31'd0, mem_misalign}, 1);
      check("mis wb_we", {31'd0, mem_wb_ctrl_reg_write}, 0);
      check("mis wb_rd", {27'd0, mem_wb_rd}, 0);
      @(posedge clk); #1;
      check("mis pulse_end", {31'd0, mem_misalign}, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
